correlator_pkt_framer: RTL and testbench

- Downstream consumer of the correlator packet FIFO. Pops 5-byte packets: {winNum, countX, countY, countIsect, countSymdiff}.
- Checks winNum continuity to detect dropped windows.
- Re-emits each packet as a framed byte stream (sync byte + payload) over a valid/ready byte pipe towards the host serial interface.
- Flushes the correlator FIFO on enable so that packet boundaries stay aligned.

---
 rtl/correlator_pkt_framer_pkg.sv | 20 ++
 rtl/correlator_pkt_framer_if.sv | 20 ++
 rtl/correlator_pkt_framer_seqcheck.sv | 43 ++++
 rtl/correlator_pkt_framer.sv | 140 ++++++++++++++
 tb/tb_correlator_pkt_framer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/correlator_pkt_framer_pkg.sv
// Shared types and constants for the correlator packet framer.
package correlator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam int         PKT_LEN_DEFAULT   = 5;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int WINNUM  = 0;
    localparam int COUNTX  = 1;
    localparam int COUNTY  = 2;
    localparam int ISECT   = 3;
    localparam int SYMDIFF = 4;

endpackage

// File: rtl/correlator_pkt_framer_if.sv
// FIFO-side and byte-pipe-side signals of the framer; names are from the framer's point of view.
interface correlator_pkt_framer_if;
    logic [7:0] i_pktfifo_data;
    logic       i_pktfifo_empty;
    logic       o_pktfifo_pop;
    logic       o_pktfifo_flush;
    logic [7:0] o_bp_data;
    logic       o_bp_valid;
    logic       i_bp_ready;

    modport master (
        input  i_pktfifo_data, i_pktfifo_empty, i_bp_ready,
        output o_pktfifo_pop, o_pktfifo_flush, o_bp_data, o_bp_valid
    );

    modport slave (
        output i_pktfifo_data, i_pktfifo_empty, i_bp_ready,
        input  o_pktfifo_pop, o_pktfifo_flush, o_bp_data, o_bp_valid
    );
endinterface

// File: rtl/correlator_pkt_framer_seqcheck.sv
// Window-number continuity checker: expected-winNum register and saturating drop counter.
module correlator_pkt_seqcheck
    import correlator_pkg::*;
#(
    parameter int DROPCOUNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_chk,
    input  logic [7:0]             i_win,
    output logic [DROPCOUNT_W-1:0] o_drop_count
);
    localparam int SW = ((DROPCOUNT_W > 8) ? DROPCOUNT_W : 8) + 1;
    localparam logic [DROPCOUNT_W-1:0] CNT_MAX = {DROPCOUNT_W{1'b1}};

    logic [7:0]             r_expected;
    logic                   r_exp_vld;
    logic [DROPCOUNT_W-1:0] r_cnt;
    logic [7:0]             w_diff;
    logic [SW-1:0]          w_sum;

    // Modular gap: equal winNums give zero, so no separate mismatch test is needed.
    assign w_diff = i_win - r_expected;
    assign w_sum  = SW'(r_cnt) + SW'(w_diff);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_expected <= 8'h00;
            r_exp_vld  <= 1'b0;
            r_cnt      <= '0;
        end else if (i_clr) begin
            r_exp_vld  <= 1'b0;
        end else if (i_chk) begin
            if (r_exp_vld)
                r_cnt <= (w_sum > SW'(CNT_MAX)) ? CNT_MAX : DROPCOUNT_W'(w_sum);
            r_expected <= i_win + 8'd1;
            r_exp_vld  <= 1'b1;
        end
    end

    assign o_drop_count = r_cnt;
endmodule

// File: rtl/correlator_pkt_framer.sv
// Pops fixed-length correlator packets and re-emits them as SYNC-prefixed byte frames.
// Optional trailing XOR checksum byte: define CORRELATOR_PKT_FRAMER_CHECKSUM_EN.
module correlator_pkt_framer
    import correlator_pkg::*;
#(
    parameter int         PKT_LEN     = PKT_LEN_DEFAULT,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         DROPCOUNT_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cg,
    input  logic                      i_enable,
    correlator_pkt_framer_if.master   io_bus,
    output logic [DROPCOUNT_W-1:0]    o_dropCount,
    output logic                      o_busy
);
`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
    localparam int FRAME_LEN = PKT_LEN + 2;
`else
    localparam int FRAME_LEN = PKT_LEN + 1;
`endif
    localparam int BUF_IW = $clog2(PKT_LEN);
    localparam int OUT_IW = $clog2(FRAME_LEN);

    state_t                  r_state, w_next_state;
    logic                    r_prev_en;
    logic [BUF_IW-1:0]       r_idx;
    logic [OUT_IW-1:0]       r_out_idx;
    logic [PKT_LEN-1:0][7:0] r_buf;
    logic [7:0]              r_bp_data;
    logic                    r_bp_valid;
    logic                    w_pop, w_flush, w_accept;
    logic                    w_last_in, w_last_out;
    logic [7:0]              w_next_byte;

    assign w_last_in  = (r_idx == BUF_IW'(PKT_LEN - 1));
    assign w_last_out = (r_out_idx == OUT_IW'(FRAME_LEN - 1));

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_accept     = 1'b0;
        if (i_cg) begin
            case (r_state)
                IDLE: if (i_enable && !r_prev_en) begin
                    w_flush      = 1'b1;
                    w_next_state = COLLECT;
                end
                COLLECT: if (!i_enable) begin
                    w_next_state = IDLE;
                end else if (!io_bus.i_pktfifo_empty) begin
                    w_pop = 1'b1;
                    if (w_last_in) w_next_state = CHECK;
                end
                CHECK: w_next_state = EMIT;
                EMIT: if (r_bp_valid && io_bus.i_bp_ready) begin
                    w_accept = 1'b1;
                    // A frame in flight always completes; disable takes effect at its end.
                    if (w_last_out) w_next_state = i_enable ? COLLECT : IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
    logic [7:0] r_csum, w_csum;

    always_comb begin
        w_csum = SYNC_BYTE;
        for (int i = 0; i < PKT_LEN; i++) w_csum = w_csum ^ r_buf[i];
    end
`endif

    // Byte presented after the one currently accepted: payload, then checksum if built in.
    always_comb begin
        w_next_byte = 8'h00;
`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
        w_next_byte = r_csum;
`endif
        if (r_out_idx < OUT_IW'(PKT_LEN)) w_next_byte = r_buf[BUF_IW'(r_out_idx)];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_prev_en  <= 1'b0;
            r_idx      <= '0;
            r_out_idx  <= '0;
            r_buf      <= '0;
            r_bp_data  <= 8'h00;
            r_bp_valid <= 1'b0;
`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else if (i_cg) begin
            r_state   <= w_next_state;
            r_prev_en <= i_enable;
            if (w_flush || (r_state == COLLECT && !i_enable)) r_idx <= '0;
            if (w_pop) begin
                r_buf[r_idx] <= io_bus.i_pktfifo_data;
                r_idx        <= w_last_in ? '0 : r_idx + 1'b1;
            end
            if (r_state == CHECK) begin
                r_bp_valid <= 1'b1;
                r_bp_data  <= SYNC_BYTE;
                r_out_idx  <= '0;
`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
                r_csum     <= w_csum;
`endif
            end
            if (w_accept) begin
                if (w_last_out) begin
                    r_bp_valid <= 1'b0;
                    r_bp_data  <= 8'h00;
                end else begin
                    r_out_idx <= r_out_idx + 1'b1;
                    r_bp_data <= w_next_byte;
                end
            end
        end
    end

    correlator_pkt_seqcheck #(.DROPCOUNT_W(DROPCOUNT_W)) u_seqcheck (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (w_flush),
        .i_chk        (i_cg && (r_state == CHECK)),
        .i_win        (r_buf[WINNUM]),
        .o_drop_count (o_dropCount)
    );

    assign io_bus.o_pktfifo_pop   = w_pop;
    assign io_bus.o_pktfifo_flush = w_flush;
    assign io_bus.o_bp_data       = r_bp_data;
    assign io_bus.o_bp_valid      = r_bp_valid;
    assign o_busy                 = (r_state != IDLE);
endmodule

// File: tb/tb_correlator_pkt_framer.sv
// Directed bench for correlator_pkt_framer: FIFO model, byte capture, hand-computed frames.
module tb_correlator_pkt_framer;
    import correlator_pkg::*;

`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
    localparam int FL = PKT_LEN_DEFAULT + 2;
`else
    localparam int FL = PKT_LEN_DEFAULT + 1;
`endif

    logic       clk = 1'b0;
    logic       rst, cg, en;
    logic [7:0] drop;
    logic       busy;

    correlator_pkt_framer_if bus_if();

    correlator_pkt_framer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cg        (cg),
        .i_enable    (en),
        .io_bus      (bus_if),
        .o_dropCount (drop),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: bench pushes at negedge, DUT pops/flushes at posedge.
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign bus_if.i_pktfifo_data  = mem[rd_ptr];
    assign bus_if.i_pktfifo_empty = (rd_ptr == wr_ptr);

    logic [7:0] cap [64];
    int         cap_cyc [64];
    int         cap_n = 0, flush_n = 0, emit_pops = 0, flush_pops = 0, cyc = 0;
    int         n_tests = 0, n_fail = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus_if.o_pktfifo_flush) rd_ptr <= wr_ptr;
            else if (bus_if.o_pktfifo_pop) rd_ptr <= rd_ptr + 8'd1;
            if (bus_if.o_pktfifo_flush) flush_n <= flush_n + 1;
            if (bus_if.o_pktfifo_flush && bus_if.o_pktfifo_pop) flush_pops <= flush_pops + 1;
            if (bus_if.o_pktfifo_pop && bus_if.o_bp_valid) emit_pops <= emit_pops + 1;
            if (cg && bus_if.o_bp_valid && bus_if.i_bp_ready) begin
                cap[cap_n[5:0]]     <= bus_if.o_bp_data;
                cap_cyc[cap_n[5:0]] <= cyc;
                cap_n               <= cap_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic push_pkt(input logic [7:0] w, a, b, c, d);
        push(w); push(a); push(b); push(c); push(d);
    endtask

    task automatic wait_cap(input int n, input string tag);
        int k = 0;
        while (cap_n < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_bytes"}, cap_n, n);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (bus_if.o_bp_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_valid"}, 32'(bus_if.o_bp_valid), 1);
    endtask

    task automatic check_frame(input int base, input logic [7:0] w, a, b, c, d, input string tag);
        logic [7:0] exp [5];
        exp = '{w, a, b, c, d};
        chk({tag, "_sync"}, cap[base], SYNC_BYTE_DEFAULT);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_b%0d", tag, i), cap[base + 1 + i], exp[i]);
`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
        chk({tag, "_csum"}, cap[base + 6], SYNC_BYTE_DEFAULT ^ w ^ a ^ b ^ c ^ d);
`endif
    endtask

    task automatic do_pkt(input logic [7:0] w, a, b, c, d, input string tag);
        int base = cap_n;
        push_pkt(w, a, b, c, d);
        wait_cap(base + FL, tag);
        check_frame(base, w, a, b, c, d, tag);
    endtask

    initial begin
        int base, base2, fl;
        rst = 1'b1; cg = 1'b1; en = 1'b0;
        bus_if.i_bp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus_if.o_bp_valid), 0);
        chk("rst_data",  32'(bus_if.o_bp_data), 0);
        chk("rst_drop",  32'(drop), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_flush", 32'(bus_if.o_pktfifo_flush), 0);
        rst = 1'b0;

        // Stale bytes sit in the FIFO; IDLE must not pop them, enable must flush them.
        push(8'h99); push(8'h98); push(8'h97);
        @(negedge clk); #1;
        chk("idle_pop", 32'(bus_if.o_pktfifo_pop), 0);
        en = 1'b1; #1;
        chk("en_flush", 32'(bus_if.o_pktfifo_flush), 1);
        chk("en_pop",   32'(bus_if.o_pktfifo_pop), 0);
        @(negedge clk); #1;
        chk("flush_once",  32'(bus_if.o_pktfifo_flush), 0);
        chk("flush_count", flush_n, 1);
        chk("flush_pops",  flush_pops, 0);
        chk("fifo_emptied", 32'(bus_if.i_pktfifo_empty), 1);
        chk("busy_collect", 32'(busy), 1);

        // Basic frame with ready held high: consecutive bytes.
        bus_if.i_bp_ready = 1'b1;
        base = cap_n;
        do_pkt(8'h07, 8'h10, 8'h20, 8'h30, 8'h40, "p07");
        chk("p07_consec", cap_cyc[base + FL - 1] - cap_cyc[base], FL - 1);
        chk("p07_drop", 32'(drop), 0);

        do_pkt(8'h0A, 8'h11, 8'h21, 8'h31, 8'h41, "p0A");
        chk("p0A_drop", 32'(drop), 2);
        do_pkt(8'h0B, 8'h12, 8'h22, 8'h32, 8'h42, "p0B");
        chk("p0B_drop", 32'(drop), 2);
        // expected 0C, got FF: gap F3
        do_pkt(8'hFF, 8'h13, 8'h23, 8'h33, 8'h43, "pFF");
        chk("pFF_drop", 32'(drop), 245);
        do_pkt(8'h00, 8'h14, 8'h24, 8'h34, 8'h44, "p00");
        chk("wrap_drop", 32'(drop), 245);

        // Backpressure: ready 1,0,0,1 during EMIT; next packet queued meanwhile.
        bus_if.i_bp_ready = 1'b0;
        base = cap_n;
        push_pkt(8'h01, 8'h15, 8'h25, 8'h35, 8'h45);
        wait_valid("stall");
        chk("stall_sync", 32'(bus_if.o_bp_data), 32'hA5);
        bus_if.i_bp_ready = 1'b1;
        @(negedge clk); #1;
        chk("stall_b1",   32'(bus_if.o_bp_data), 32'h01);
        chk("stall_cnt1", cap_n, base + 1);
        bus_if.i_bp_ready = 1'b0;
        @(negedge clk); #1;
        chk("stall_hold1", 32'(bus_if.o_bp_data), 32'h01);
        push_pkt(8'h02, 8'h16, 8'h26, 8'h36, 8'h46);
        @(negedge clk); #1;
        chk("stall_hold2", 32'(bus_if.o_bp_data), 32'h01);
        chk("stall_cnt2",  cap_n, base + 1);
        bus_if.i_bp_ready = 1'b1;
        wait_cap(base + FL, "p01");
        check_frame(base, 8'h01, 8'h15, 8'h25, 8'h35, 8'h45, "p01");
        base2 = base + FL;
        wait_cap(base2 + FL, "p02");
        check_frame(base2, 8'h02, 8'h16, 8'h26, 8'h36, 8'h46, "p02");
        chk("emit_pops", emit_pops, 0);
        chk("p02_drop", 32'(drop), 245);

        // Disable after 3 of 5 bytes: partial packet dropped, no output.
        base = cap_n;
        push(8'h30); push(8'h31); push(8'h32);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk); #1;
        chk("dis_busy", 32'(busy), 0);
        chk("dis_popped", 32'(bus_if.i_pktfifo_empty), 1);
        repeat (3) @(negedge clk);
        chk("dis_noout", cap_n, base);
        fl = flush_n;
        en = 1'b1; #1;
        chk("reen_flush", 32'(bus_if.o_pktfifo_flush), 1);
        @(negedge clk);
        chk("reen_count", flush_n, fl + 1);
        do_pkt(8'h50, 8'h17, 8'h27, 8'h37, 8'h47, "p50");
        chk("p50_drop", 32'(drop), 245);

        // Clock gate while valid: no transfer; then gap 1F saturates the counter.
        base = cap_n;
        push_pkt(8'h70, 8'h18, 8'h28, 8'h38, 8'h48);
        wait_valid("cg");
        cg = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("cg_nocap", cap_n, base);
        chk("cg_hold",  32'(bus_if.o_bp_valid), 1);
        cg = 1'b1;
        wait_cap(base + FL, "p70");
        check_frame(base, 8'h70, 8'h18, 8'h28, 8'h38, 8'h48, "p70");
        chk("sat_drop", 32'(drop), 255);

`ifdef CORRELATOR_PKT_FRAMER_CHECKSUM_EN
        base = cap_n;
        do_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, "pcs");
        chk("csum_A4", cap[base + 6], 32'hA4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
